// File: rtl/paint_pkg.sv
// Shared types and constants for the brush painting path.
package paint_pkg;

  typedef logic [7:0] coord_t;
  typedef logic [2:0] color_t;

  typedef struct packed {
    color_t color;
    coord_t x;
    coord_t y;
  } brush_entry_t;

  localparam color_t COLOR_CLEAR = 3'b000;
  localparam color_t COLOR_RESET = 3'b111;

  typedef enum logic [1:0] {IDLE, LOAD, PAINT, CLEAR} sched_state_t;

endpackage

// File: rtl/brush_fifo.sv
// Brush-point queue: synchronous FIFO of brush_entry_t with flush.
module brush_fifo
  import paint_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  brush_entry_t din,
  output brush_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  brush_entry_t  mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the same cycle pops.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // A push coinciding with the flush survives as the sole entry.
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      if (push) mem[0] <= din;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/brush_scheduler.sv
// Expands queued brush points into pixel stamps and runs clear-screen sweeps.
// Define BRUSH_ROUND_EN to drop the four stamp corners (rounded brush).
module brush_scheduler
  import paint_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned BRUSH_SIZE = 3,
  parameter int unsigned X_MAX      = 159,
  parameter int unsigned Y_MAX      = 119
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       brushUpdate,
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       colorUpdate,
  input  logic [2:0] newColor,
  input  logic       clearReq,
  input  logic       fbGnt,
  output logic       fbReq,
  output logic       fbWe,
  output logic [7:0] fbX,
  output logic [7:0] fbY,
  output logic [2:0] fbData,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned     R  = (BRUSH_SIZE - 1) / 2;
  localparam logic signed [8:0] RS = 9'(R);
  localparam logic signed [8:0] XM = 9'(X_MAX);
  localparam logic signed [8:0] YM = 9'(Y_MAX);

  sched_state_t      state, state_nx;
  color_t            cur_color;
  brush_entry_t      stroke, fifo_din, fifo_dout;
  logic              fifo_full, fifo_empty, fifo_pop, fifo_flush;
  logic              clear_pending;
  logic signed [8:0] dx, dy, tx, ty;
  coord_t            clr_x, clr_y;
  logic              in_range, corner, advance, last_off, last_clr;

  assign fifo_din = '{color: (colorUpdate ? newColor : cur_color), x: x, y: y};

  brush_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (brushUpdate),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign tx       = $signed({1'b0, stroke.x}) + dx;
  assign ty       = $signed({1'b0, stroke.y}) + dy;
  assign in_range = (tx >= 9'sd0) && (tx <= XM) && (ty >= 9'sd0) && (ty <= YM);
  assign last_off = (dx == RS) && (dy == RS);
  assign last_clr = (clr_x == coord_t'(X_MAX)) && (clr_y == coord_t'(Y_MAX));

`ifdef BRUSH_ROUND_EN
  assign corner = (R > 0) && ((dx == RS) || (dx == -RS)) && ((dy == RS) || (dy == -RS));
`else
  assign corner = 1'b0;
`endif

  assign fbWe = fbReq & fbGnt;
  assign busy = (state != IDLE) | ~fifo_empty | clear_pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    advance    = 1'b0;
    fbReq      = 1'b0;
    fbX        = '0;
    fbY        = '0;
    fbData     = '0;
    unique case (state)
      IDLE: begin
        if (clear_pending) begin
          fifo_flush = 1'b1;
          state_nx   = CLEAR;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_nx = LOAD;
        end
      end
      LOAD: state_nx = PAINT;
      PAINT: begin
        if (in_range && !corner) begin
          fbReq  = 1'b1;
          fbX    = tx[7:0];
          fbY    = ty[7:0];
          fbData = stroke.color;
        end
        advance = ~fbReq | fbGnt;
        if (advance && last_off) state_nx = IDLE;
      end
      CLEAR: begin
        fbReq   = 1'b1;
        fbX     = clr_x;
        fbY     = clr_y;
        fbData  = COLOR_CLEAR;
        advance = fbGnt;
        if (fbGnt && last_clr) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_color     <= COLOR_RESET;
      clear_pending <= 1'b0;
      overflow      <= 1'b0;
      stroke        <= '0;
      dx            <= '0;
      dy            <= '0;
      clr_x         <= '0;
      clr_y         <= '0;
    end else begin
      if (colorUpdate) cur_color <= newColor;
      if (clearReq)        clear_pending <= 1'b1;
      else if (fifo_flush) clear_pending <= 1'b0;
      if (brushUpdate && fifo_full && !fifo_pop) overflow <= 1'b1;
      if (fifo_pop) stroke <= fifo_dout;
      if (state == LOAD) begin
        dx <= -RS;
        dy <= -RS;
      end else if (state == PAINT && advance) begin
        if (dx == RS) begin
          dx <= -RS;
          dy <= dy + 9'sd1;
        end else begin
          dx <= dx + 9'sd1;
        end
      end
      if (fifo_flush) begin
        clr_x <= '0;
        clr_y <= '0;
      end else if (state == CLEAR && advance) begin
        if (clr_x == coord_t'(X_MAX)) begin
          clr_x <= '0;
          clr_y <= clr_y + 8'd1;
        end else begin
          clr_x <= clr_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_brush_scheduler.sv
// Directed bench for brush_scheduler; expectations follow BRUSH_ROUND_EN when defined.
module tb_brush_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       brushUpdate = 1'b0;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       colorUpdate = 1'b0;
  logic [2:0] newColor = '0;
  logic       clearReq = 1'b0;
  logic       fbGnt = 1'b0;
  logic       fbReq, fbWe, busy, overflow;
  logic [7:0] fbX, fbY;
  logic [2:0] fbData;

  brush_scheduler #(
    .FIFO_DEPTH(4),
    .BRUSH_SIZE(3),
    .X_MAX(159),
    .Y_MAX(119)
  ) dut (
    .clk(clk), .reset(reset), .brushUpdate(brushUpdate), .x(x), .y(y),
    .colorUpdate(colorUpdate), .newColor(newColor), .clearReq(clearReq),
    .fbGnt(fbGnt), .fbReq(fbReq), .fbWe(fbWe), .fbX(fbX), .fbY(fbY),
    .fbData(fbData), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

`ifdef BRUSH_ROUND_EN
  localparam int NSTAMP = 5;
`else
  localparam int NSTAMP = 9;
`endif

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned pulse_cyc;

  logic [7:0]  wx[$];
  logic [7:0]  wy[$];
  logic [2:0]  wd[$];
  int unsigned wc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset && fbWe) begin
      wx.push_back(fbX);
      wy.push_back(fbY);
      wd.push_back(fbData);
      wc.push_back(cyc);
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] xy(input int ax, input int ay);
    return {8'(ax), 8'(ay)};
  endfunction

  task automatic clear_log();
    wx.delete(); wy.delete(); wd.delete(); wc.delete();
  endtask

  task automatic pulse_brush(input int px, input int py, input logic cu, input logic [2:0] nc);
    @(posedge clk); #1;
    x = 8'(px); y = 8'(py); brushUpdate = 1'b1;
    colorUpdate = cu; newColor = nc;
    pulse_cyc = cyc;
    @(posedge clk); #1;
    brushUpdate = 1'b0; colorUpdate = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned budget, output int unsigned fall);
    int unsigned n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    fall = cyc;
  endtask

  task automatic check_writes(input string tag, input logic [15:0] e[$], input logic [2:0] d);
    check($sformatf("%s_count", tag), wx.size(), e.size());
    foreach (e[i])
      if (i < wx.size()) begin
        check($sformatf("%s_xy%0d", tag, i), {wx[i], wy[i]}, e[i]);
        check($sformatf("%s_data%0d", tag, i), 32'(wd[i]), 32'(d));
      end
  endtask

  initial begin
    logic [15:0]  eq[$];
    int unsigned  fall, n, t, zeros;
    logic [15:0]  stall_xy;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_fbReq", 32'(fbReq), 0);
    check("rst_fbWe", 32'(fbWe), 0);
    check("rst_fbXY", {fbX, fbY}, 0);
    check("rst_fbData", 32'(fbData), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    @(posedge clk); #1 reset = 1'b1;

    // plain stamp with a previously loaded colour
    fbGnt = 1'b1;
    @(posedge clk); #1 colorUpdate = 1'b1; newColor = 3'b101;
    @(posedge clk); #1 colorUpdate = 1'b0;
    clear_log();
    pulse_brush(10, 20, 1'b0, 3'b000);
    wait_idle(100, fall);
`ifdef BRUSH_ROUND_EN
    eq = '{xy(10,19), xy(9,20), xy(10,20), xy(11,20), xy(10,21)};
`else
    eq = '{xy(9,19), xy(10,19), xy(11,19), xy(9,20), xy(10,20), xy(11,20),
           xy(9,21), xy(10,21), xy(11,21)};
`endif
    check_writes("stamp", eq, 3'b101);
    if (wc.size() > 0) begin
      check("stamp_latency", wc[0] - pulse_cyc, 3);
      check("stamp_busy_fall", fall, wc[wc.size()-1] + 1);
    end else check("stamp_latency", 0, 3);

    // edge clipping; colour update in the same cycle as the point
    clear_log();
    pulse_brush(0, 0, 1'b1, 3'b011);
    wait_idle(100, fall);
`ifdef BRUSH_ROUND_EN
    eq = '{xy(0,0), xy(1,0), xy(0,1)};
`else
    eq = '{xy(0,0), xy(1,0), xy(0,1), xy(1,1)};
`endif
    check_writes("edge00", eq, 3'b011);
    clear_log();
    pulse_brush(159, 119, 1'b0, 3'b000);
    wait_idle(100, fall);
`ifdef BRUSH_ROUND_EN
    eq = '{xy(159,118), xy(158,119), xy(159,119)};
`else
    eq = '{xy(158,118), xy(159,118), xy(158,119), xy(159,119)};
`endif
    check_writes("edgemax", eq, 3'b011);

    // grant stall after the second write
    clear_log();
    pulse_brush(10, 20, 1'b0, 3'b000);
    n = 0; t = 0;
    while (n < 2 && t < 50) begin
      @(negedge clk);
      if (fbWe) n++;
      t++;
    end
    check("stall_reach", n, 2);
    @(posedge clk); #1 fbGnt = 1'b0;
`ifdef BRUSH_ROUND_EN
    stall_xy = xy(10, 20);
`else
    stall_xy = xy(11, 19);
`endif
    repeat (5) begin
      @(negedge clk);
      check("stall_req", 32'(fbReq), 1);
      check("stall_we", 32'(fbWe), 0);
      check("stall_xy", {fbX, fbY}, stall_xy);
      check("stall_data", 32'(fbData), 32'(3'b011));
    end
    @(posedge clk); #1 fbGnt = 1'b1;
    wait_idle(100, fall);
`ifdef BRUSH_ROUND_EN
    eq = '{xy(10,19), xy(9,20), xy(10,20), xy(11,20), xy(10,21)};
`else
    eq = '{xy(9,19), xy(10,19), xy(11,19), xy(9,20), xy(10,20), xy(11,20),
           xy(9,21), xy(10,21), xy(11,21)};
`endif
    check_writes("stall", eq, 3'b011);

    // overflow: 7 back-to-back points with no grant
    fbGnt = 1'b0;
    clear_log();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      brushUpdate = 1'b1; x = 8'(50 + i); y = 8'd60;
      if (i == 5) check("ovf_before_drop", 32'(overflow), 0);
      if (i == 6) check("ovf_after_drop", 32'(overflow), 1);
    end
    @(posedge clk); #1 brushUpdate = 1'b0;
    @(negedge clk);
    check("ovf_sticky", 32'(overflow), 1);
    check("ovf_stall_req", 32'(fbReq), 1);
`ifdef BRUSH_ROUND_EN
    check("ovf_stall_xy", {fbX, fbY}, xy(50, 59));
`else
    check("ovf_stall_xy", {fbX, fbY}, xy(49, 59));
`endif
    @(posedge clk); #1 fbGnt = 1'b1;
    wait_idle(300, fall);
    check("ovf_writes", wx.size(), 5 * NSTAMP);
    if (wx.size() > 0) begin
`ifdef BRUSH_ROUND_EN
      check("ovf_last_xy", {wx[wx.size()-1], wy[wy.size()-1]}, xy(54, 61));
`else
      check("ovf_last_xy", {wx[wx.size()-1], wy[wy.size()-1]}, xy(55, 61));
`endif
    end
    check("ovf_hold", 32'(overflow), 1);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("ovf_reset", 32'(overflow), 0);
    check("ovf_reset_busy", 32'(busy), 0);
    @(posedge clk); #1 reset = 1'b1;

    // clear requested at the 4th write of a stroke; queued points are flushed
    clear_log();
    fbGnt = 1'b1;
    @(posedge clk); #1 brushUpdate = 1'b1; x = 8'd10; y = 8'd20;
    colorUpdate = 1'b1; newColor = 3'b110;
    @(posedge clk); #1 x = 8'd30; y = 8'd30; colorUpdate = 1'b0;
    @(posedge clk); #1 x = 8'd40; y = 8'd40;
    @(posedge clk); #1 brushUpdate = 1'b0;
    n = 0; t = 0;
    while (n < 4 && t < 50) begin
      @(negedge clk);
      if (fbWe) n++;
      t++;
    end
    check("clr_reach", n, 4);
    clearReq = 1'b1;
    @(posedge clk); #1 clearReq = 1'b0;
    wait_idle(25000, fall);
    check("clr_total", wx.size(), NSTAMP + 19200);
    if (wx.size() == NSTAMP + 19200) begin
      check("clr_stamp_last_data", 32'(wd[NSTAMP-1]), 32'(3'b110));
`ifdef BRUSH_ROUND_EN
      check("clr_stamp_last_xy", {wx[NSTAMP-1], wy[NSTAMP-1]}, xy(10, 21));
`else
      check("clr_stamp_last_xy", {wx[NSTAMP-1], wy[NSTAMP-1]}, xy(11, 21));
`endif
      check("clr_first", {wx[NSTAMP], wy[NSTAMP], 5'(wd[NSTAMP])}, 0);
      check("clr_row1", {wx[NSTAMP+160], wy[NSTAMP+160]}, xy(0, 1));
      check("clr_last", {wx[wx.size()-1], wy[wy.size()-1], 5'(wd[wd.size()-1])},
            {xy(159, 119), 5'd0});
      zeros = 0;
      foreach (wd[i]) if (wd[i] == 3'b000) zeros++;
      check("clr_zero_count", zeros, 19200);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
